// File: rtl/dijkstra_controller.sv
// Drives a priority-queue distance store through single-source shortest path; about MAX_NODES+2*SETTLE_CYCLES+1+2*MAX_NODES cycles per settled node.
// No backpressure: queue writes are single-cycle pulses and adjacency/queue reads are assumed to return one cycle after their address.
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 8
`endif

module dijkstra_controller #(
  parameter int MAX_NODES     = 8,
  parameter int INDEX_WIDTH   = `DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH   = `DEFAULT_VALUE_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [INDEX_WIDTH-1:0]         source,
  output logic [2*INDEX_WIDTH-1:0]       adj_addr,
  input  logic [VALUE_WIDTH-1:0]         adj_weight,
  output logic                           pq_set_en,
  output logic [INDEX_WIDTH-1:0]         pq_index,
  output logic [VALUE_WIDTH-1:0]         pq_write_value,
  input  logic [VALUE_WIDTH-1:0]         pq_read_value,
  input  logic [INDEX_WIDTH-1:0]         pq_min_index,
  input  logic [VALUE_WIDTH-1:0]         pq_min_value,
  output logic [INDEX_WIDTH*MAX_NODES-1:0] pq_mask_flat,
  output logic [INDEX_WIDTH*MAX_NODES-1:0] prev_flat,
  output logic                           busy,
  output logic                           done
);

  localparam logic [INDEX_WIDTH-1:0] UNVISITED = '1;
  localparam logic [VALUE_WIDTH-1:0] INFINITY  = '1;
  localparam logic [INDEX_WIDTH-1:0] LAST_NODE = INDEX_WIDTH'(MAX_NODES - 1);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam int SW = $clog2(MAX_NODES + 1);
  localparam logic [SW-1:0] ALL_SETTLED = SW'(MAX_NODES);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SETTLE, S_SELECT, S_SETTLE_M, S_RELAX_ISSUE, S_RELAX_CHECK, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]   src_q, u_q, v_q;
  logic [VALUE_WIDTH-1:0]   du_q;
  logic [CW-1:0]            cnt_q;
  logic [SW-1:0]            n_settled_q;
  logic [INDEX_WIDTH-1:0]   mask_q [MAX_NODES];
  logic [INDEX_WIDTH-1:0]   prev_q [MAX_NODES];
  logic [VALUE_WIDTH:0]     alt;
  logic                     v_open;
  logic                     relax_ok;

  // alt is one bit wider so a saturating sum is seen as >= INFINITY instead of wrapping
  assign alt = {1'b0, du_q} + {1'b0, adj_weight};

  always_comb begin
    v_open = 1'b0;
    for (int j = 0; j < MAX_NODES; j++) begin
      if (v_q == INDEX_WIDTH'(j)) v_open = (mask_q[j] == UNVISITED);
    end
  end

  assign relax_ok = (adj_weight != INFINITY) && v_open &&
                    (alt < {1'b0, INFINITY}) && (alt < {1'b0, pq_read_value});

  always_comb begin
    state_d        = state_q;
    pq_set_en      = 1'b0;
    pq_write_value = '0;
    case (state_q)
      S_IDLE:        if (start) state_d = S_INIT;
      S_INIT: begin
        pq_set_en      = 1'b1;
        pq_write_value = (v_q == src_q) ? '0 : INFINITY;
        if (v_q == LAST_NODE) state_d = S_SETTLE;
      end
      S_SETTLE:      if (cnt_q == SETTLE_LAST) state_d = S_SELECT;
      S_SELECT: begin
        if (pq_min_value == INFINITY || n_settled_q == ALL_SETTLED) state_d = S_DONE;
        else                                                          state_d = S_SETTLE_M;
      end
      S_SETTLE_M:    if (cnt_q == SETTLE_LAST) state_d = S_RELAX_ISSUE;
      S_RELAX_ISSUE: state_d = S_RELAX_CHECK;
      S_RELAX_CHECK: begin
        if (relax_ok) begin
          pq_set_en      = 1'b1;
          pq_write_value = alt[VALUE_WIDTH-1:0];
        end
        state_d = (v_q == LAST_NODE) ? S_SETTLE : S_RELAX_ISSUE;
      end
      S_DONE:        state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      u_q         <= '0;
      v_q         <= '0;
      du_q        <= '0;
      cnt_q       <= '0;
      n_settled_q <= '0;
      for (int j = 0; j < MAX_NODES; j++) begin
        mask_q[j] <= UNVISITED;
        prev_q[j] <= UNVISITED;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_q       <= source;
            v_q         <= '0;
            n_settled_q <= '0;
            for (int j = 0; j < MAX_NODES; j++) begin
              mask_q[j] <= UNVISITED;
              prev_q[j] <= (source == INDEX_WIDTH'(j)) ? INDEX_WIDTH'(j) : UNVISITED;
            end
          end
        end
        S_INIT: if (v_q != LAST_NODE) v_q <= v_q + 1'b1;
        S_SELECT: begin
          u_q  <= pq_min_index;
          du_q <= pq_min_value;
          if (state_d == S_SETTLE_M) begin
            n_settled_q <= n_settled_q + 1'b1;
            v_q         <= '0;
            for (int j = 0; j < MAX_NODES; j++) begin
              if (pq_min_index == INDEX_WIDTH'(j)) mask_q[j] <= INDEX_WIDTH'(j);
            end
          end
        end
        S_RELAX_CHECK: begin
          for (int j = 0; j < MAX_NODES; j++) begin
            if (relax_ok && v_q == INDEX_WIDTH'(j)) prev_q[j] <= u_q;
          end
          if (v_q != LAST_NODE) v_q <= v_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar j = 0; j < MAX_NODES; j++) begin : g_flat
    assign pq_mask_flat[j*INDEX_WIDTH +: INDEX_WIDTH] = mask_q[j];
    assign prev_flat[j*INDEX_WIDTH +: INDEX_WIDTH]    = prev_q[j];
  end

  assign adj_addr = {u_q, v_q};
  assign pq_index = v_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_dijkstra_controller.sv
// Bench for dijkstra_controller: behavioural adjacency memory and priority queue, vector table of graphs, scoreboard of expected results.
module tb_dijkstra_controller;
  localparam int N = 8;
  localparam logic [7:0] INF = 8'hFF;
  localparam logic [3:0] UV  = 4'hF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  source = 4'd0;
  logic [7:0]  adj_addr;
  logic [7:0]  adj_weight;
  logic        pq_set_en;
  logic [3:0]  pq_index;
  logic [7:0]  pq_write_value;
  logic [7:0]  pq_read_value;
  logic [3:0]  pq_min_index;
  logic [7:0]  pq_min_value;
  logic [31:0] pq_mask_flat;
  logic [31:0] prev_flat;
  logic        busy;
  logic        done;

  dijkstra_controller dut (
    .clock(clock), .reset(reset), .start(start), .source(source),
    .adj_addr(adj_addr), .adj_weight(adj_weight),
    .pq_set_en(pq_set_en), .pq_index(pq_index), .pq_write_value(pq_write_value),
    .pq_read_value(pq_read_value), .pq_min_index(pq_min_index), .pq_min_value(pq_min_value),
    .pq_mask_flat(pq_mask_flat), .prev_flat(prev_flat), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // behavioural memories: registered reads, lowest index wins min ties
  logic [7:0] adj_mem [0:255];
  logic [7:0] pq_dist [0:7];
  logic       scramble = 1'b0;
  logic [3:0] mi;
  logic [7:0] mv;

  always_comb begin
    mv = INF;
    mi = 4'd0;
    for (int i = 0; i < N; i++) begin
      if (pq_mask_flat[i*4 +: 4] == UV && pq_dist[i] < mv) begin
        mv = pq_dist[i];
        mi = 4'(i);
      end
    end
  end

  always @(posedge clock) begin
    adj_weight    <= adj_mem[adj_addr];
    pq_read_value <= pq_index[3] ? INF : pq_dist[pq_index[2:0]];
    pq_min_index  <= mi;
    pq_min_value  <= mv;
    if (scramble) begin
      for (int i = 0; i < N; i++) pq_dist[i] <= 8'h5A;
    end else if (pq_set_en && !pq_index[3]) begin
      pq_dist[pq_index[2:0]] <= pq_write_value;
    end
  end

  int done_cnt = 0;
  always @(negedge clock) if (done === 1'b1) done_cnt++;

  typedef struct packed {
    logic [3:0]         src;
    logic [3:0]         n_edges;
    logic [0:8][15:0]   edges;     // {u,v,weight}
    logic [0:7][7:0]    exp_dist;
    logic [0:7][3:0]    exp_prev;
    logic [0:7][3:0]    exp_mask;
  } vec_t;

  vec_t vecs [0:7];
  vec_t exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic [3:0] s, input logic [3:0] ne, input logic [143:0] ed,
                              input logic [63:0] d, input logic [31:0] p, input logic [31:0] m);
    vec_t r;
    r.src = s; r.n_edges = ne; r.edges = ed;
    r.exp_dist = d; r.exp_prev = p; r.exp_mask = m;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " pq_set_en"}, 64'(pq_set_en), 64'd0);
    chk({tag, " pq_index"}, 64'(pq_index), 64'd0);
    chk({tag, " pq_write_value"}, 64'(pq_write_value), 64'd0);
    chk({tag, " adj_addr"}, 64'(adj_addr), 64'd0);
    chk({tag, " mask"}, 64'(pq_mask_flat), 64'hFFFF_FFFF);
    chk({tag, " prev"}, 64'(prev_flat), 64'hFFFF_FFFF);
  endtask

  task automatic load_graph(input vec_t v);
    for (int a = 0; a < 256; a++) adj_mem[a] = INF;
    for (int k = 0; k < int'(v.n_edges); k++) adj_mem[v.edges[k][15:8]] = v.edges[k][7:0];
    @(negedge clock); scramble = 1'b1;
    @(negedge clock); scramble = 1'b0;
  endtask

  task automatic run_vec(input int i, input bit spam);
    vec_t e;
    int cyc, d0, drops, k, bound;
    bit seen;
    load_graph(vecs[i]);
    exp_q.push_back(vecs[i]);
    d0 = done_cnt; drops = 0; seen = 1'b0; cyc = 0;
    source = vecs[i].src;
    start  = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      cyc = c + 1;
      if (done === 1'b1) begin seen = 1'b1; break; end
      if (busy !== 1'b1) drops++;
      start  = spam && (c % 6 == 2);
      source = spam ? 4'd3 : vecs[i].src;
    end
    start = 1'b0;
    chk($sformatf("v%0d done_seen", i), 64'(seen), 64'd1);
    chk($sformatf("v%0d busy_at_done", i), 64'(busy), 64'd0);
    chk($sformatf("v%0d busy_drops", i), 64'(drops), 64'd0);
    repeat (4) @(negedge clock);
    chk($sformatf("v%0d done_count", i), 64'(done_cnt - d0), 64'd1);
    e = exp_q.pop_front();
    k = 0;
    for (int j = 0; j < N; j++) begin
      if (e.exp_mask[j] != UV) k++;
      chk($sformatf("v%0d dist[%0d]", i, j), 64'(pq_dist[j]), 64'(e.exp_dist[j]));
      chk($sformatf("v%0d prev[%0d]", i, j), 64'(prev_flat[j*4 +: 4]), 64'(e.exp_prev[j]));
      chk($sformatf("v%0d mask[%0d]", i, j), 64'(pq_mask_flat[j*4 +: 4]), 64'(e.exp_mask[j]));
    end
    bound = N + 2 + k * (2*2 + 1 + 2*N + N) + 2 + 4;
    chk($sformatf("v%0d latency_ok(%0d)", i, cyc), 64'(cyc <= bound), 64'd1);
  endtask

  initial begin
    bit hit;
    // edges are {u,v,w}; expected arrays are listed node 0 first
    vecs[0] = mk(4'd0, 4'd4, {16'h0104, 16'h0201, 16'h2102, 16'h1305, 80'h0},
                 64'h00030108_FFFFFFFF, 32'h0201FFFF, 32'h0123FFFF);
    vecs[1] = mk(4'd0, 4'd3, {16'h0104, 16'h0201, 16'h2102, 96'h0},
                 64'h000301FF_FFFFFFFF, 32'h020FFFFF, 32'h012FFFFF);
    vecs[2] = mk(4'd2, 4'd4, {16'h0104, 16'h0201, 16'h2102, 16'h1305, 80'h0},
                 64'hFF020007_FFFFFFFF, 32'hF221FFFF, 32'hF123FFFF);
    vecs[3] = mk(4'd0, 4'd2, {16'h01FE, 16'h1205, 112'h0},
                 64'h00FEFFFF_FFFFFFFF, 32'h00FFFFFF, 32'h01FFFFFF);
    vecs[4] = mk(4'd0, 4'd2, {16'h01FA, 16'h1205, 112'h0},
                 64'h00FAFFFF_FFFFFFFF, 32'h00FFFFFF, 32'h01FFFFFF);
    vecs[5] = mk(4'd0, 4'd8, {16'h0101, 16'h1201, 16'h2301, 16'h3401, 16'h4501, 16'h5601,
                              16'h6701, 16'h070A, 16'h0},
                 64'h00010203_04050607, 32'h00123456, 32'h01234567);
    vecs[6] = mk(4'd0, 4'd4, {16'h0103, 16'h0203, 16'h1301, 16'h2301, 80'h0},
                 64'h00030304_FFFFFFFF, 32'h0001FFFF, 32'h0123FFFF);
    vecs[7] = mk(4'd7, 4'd2, {16'h7703, 16'h7002, 112'h0},
                 64'h02FFFFFF_FFFFFF00, 32'h7FFFFFF7, 32'h0FFFFFF7);

    for (int a = 0; a < 256; a++) adj_mem[a] = INF;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 8; i++) run_vec(i, 1'b0);

    // start pulsed throughout a run must not restart it
    run_vec(0, 1'b1);

    // reset dropped while a relaxation write is on the queue port
    load_graph(vecs[0]);
    source = 4'd0;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (pq_set_en === 1'b1 && pq_index == 4'd1 && pq_write_value == 8'd4) begin
        hit = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk("midrun relax_write_seen", 64'(hit), 64'd1);
    begin
      int d0;
      d0 = done_cnt;
      reset = 1'b0;
      #1;
      check_reset_outputs("midrun");
      repeat (3) @(negedge clock);
      chk("midrun no_done", 64'(done_cnt - d0), 64'd0);
    end
    reset = 1'b1;
    @(negedge clock);
    run_vec(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dijkstra_controller.md
Name: dijkstra_controller

Overview:
- Master-side driver for the PriorityQueue distance store; runs single-source shortest path over a MAX_NODES graph.
- Reads edge weights from an external adjacency memory.
- Extracts the minimum unsettled node through the queue's min_index/min_value outputs.
- Relaxes that node's neighbours by writing the queue through its set_en/index/write_value port.
- Publishes the predecessor vector and a done pulse.

Parameters:
MAX_NODES, 8, number of graph nodes
INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, node index width; must satisfy 2^INDEX_WIDTH > MAX_NODES
VALUE_WIDTH, `DEFAULT_VALUE_WIDTH, distance/weight width; all-ones = INFINITY
SETTLE_CYCLES, 2, cycles waited after any queue write before min outputs are sampled

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin run; sampled only in IDLE
source  in  INDEX_WIDTH  source node; latched on accepted start
adj_addr  out  2*INDEX_WIDTH  {u,v} edge address
adj_weight  in  VALUE_WIDTH  weight u->v, valid 1 cycle after adj_addr; INFINITY = no edge
pq_set_en  out  1  queue write strobe
pq_index  out  INDEX_WIDTH  queue read/write index
pq_write_value  out  VALUE_WIDTH  queue write data
pq_read_value  in  VALUE_WIDTH  dist[pq_index], valid 1 cycle after pq_index changes
pq_min_index  in  INDEX_WIDTH  queue's minimum unmasked index
pq_min_value  in  VALUE_WIDTH  queue's minimum unmasked value
pq_mask_flat  out  INDEX_WIDTH*MAX_NODES  entry j = UNVISITED (all-ones) while j is unsettled, else j; queue searches only UNVISITED entries
prev_flat  out  INDEX_WIDTH*MAX_NODES  predecessor of node j in slice j; UNVISITED if unreached
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at run end

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; busy=0, done=0, pq_set_en=0; pq_index=0, pq_write_value=0, adj_addr=0.
  - All pq_mask_flat and prev_flat entries = UNVISITED.
- Reset asserted mid-run aborts immediately to these values. No done pulse is produced.
- Write rule: pq_set_en is a single-cycle pulse. While the pulse is high, pq_index and pq_write_value are stable. pq_set_en is never left undriven.
- IDLE:
  - start=1 latches source and sets busy=1, then goes to INIT.
  - start while busy is ignored.
- INIT:
  - Issues one write per node j=0..MAX_NODES-1: value 0 for the source, INFINITY otherwise. That is MAX_NODES write cycles.
  - Clears all mask and prev entries to UNVISITED, then sets prev[source]=source.
  - Goes to SETTLE.
- SETTLE: waits SETTLE_CYCLES cycles, then goes to SELECT.
- SELECT:
  - Samples pq_min_index into u and pq_min_value into du.
  - If du==INFINITY or all nodes are settled: go to DONE.
  - Otherwise: mask[u]=u, v=0, go to SETTLE_M (SETTLE_CYCLES wait, so the queue sees the new mask), then RELAX_ISSUE.
- RELAX_ISSUE: drives adj_addr={u,v} and pq_index=v, then goes to RELAX_CHECK.
- RELAX_CHECK:
  - alt = du + adj_weight, computed at VALUE_WIDTH+1 bits.
  - Update when all hold: adj_weight != INFINITY, mask[v] == UNVISITED, alt < INFINITY, and alt < pq_read_value.
  - On update: one-cycle write of alt to index v and prev[v]=u.
  - Then, if v==MAX_NODES-1, go to SETTLE (SETTLE then SELECT). Otherwise v=v+1 and go to RELAX_ISSUE.
  - Self-edge u->u is never applied, because u is already masked.
  - Overflow: alt >= INFINITY is never written. Distances saturate by omission, never wrap.
- DONE:
  - done=1 for one cycle and busy=0; return to IDLE.
  - prev_flat and pq_mask_flat hold their values until the next start.
- Latency bound per run: INIT MAX_NODES + per settled node (2*SETTLE_CYCLES + 1 + 2*MAX_NODES + writes) + final SETTLE/SELECT/DONE.

Test Plan:
- 4-node graph, source 0, edges 0->1=4, 0->2=1, 2->1=2, 1->3=5, others INFINITY, behavioural queue model -> done pulse; dist={0,3,1,8}; prev={0,2,0,1}.
- Same graph with node 3 isolated -> dist[3]=INFINITY; prev[3]=UNVISITED; done fires after 3 selections.
- source=2 on that graph -> dist[2]=0, dist[1]=2, dist[3]=7, dist[0]=INFINITY; prev[0]=UNVISITED.
- Edge weight INFINITY-1 from source, du=0, plus second hop weight 5 -> first hop written; second hop alt>=INFINITY is not written; the target stays INFINITY.
- Pulse start repeatedly during a run -> no restart; exactly one done; busy is continuous.
- Drop reset low during RELAX_CHECK -> outputs return to reset values within the same cycle; a new start then completes the first scenario correctly.
